song_selector: RTL and testbench

SONG_SELECTOR -- requirements
Module: song_selector

---
 rtl/song_selector_pkg.sv | 12 +
 rtl/song_selector_btn_debounce.sv | 49 ++++
 rtl/song_selector.sv | 131 +++++++++++++
 tb/tb_song_selector.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/song_selector_pkg.sv
// Shared types and constants for the song selector: FSM state encoding and browse mode code.
package song_sel_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BROWSE = 2'd1,
        REQ    = 2'd2
    } state_e;

    localparam logic [2:0] MODE_BROWSE = 3'd1;

endpackage

// File: rtl/song_selector_btn_debounce.sv
// Button conditioner: 2-flop synchronizer, stability counter, debounced level and 1-cycle rise pulse.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic level_o,
    output logic rise_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;
    logic          level_q;
    logic          rise_q;
    logic          differs;
    logic          accept;

    assign differs = (sync_q[1] != level_q);
    assign accept  = differs && (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q  <= 2'b00;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], btn_i};
            rise_q <= accept && sync_q[1];
            // Any sample that agrees with the current level restarts the stability window.
            if (!differs || accept) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (accept) begin
                level_q <= sync_q[1];
            end
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;

endmodule

// File: rtl/song_selector.sv
// Song browser/selector with ready/valid hand-off to the player.
// Optional held-button auto-repeat is enabled by defining SONG_SELECTOR_AUTOREPEAT_EN.
module song_selector
    import song_sel_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int NUM_SONGS       = 3,
    parameter int REPEAT_CYCLES   = 25000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_sel,
    input  logic [2:0] mode,
    output logic [3:0] num,
    output logic       sel_valid,
    output logic [3:0] sel_song,
    input  logic       sel_ready
);

    localparam logic [3:0] LAST_SONG = 4'(NUM_SONGS);

    function automatic logic [3:0] num_inc(input logic [3:0] n);
        return (n >= LAST_SONG) ? 4'd1 : n + 4'd1;
    endfunction

    function automatic logic [3:0] num_dec(input logic [3:0] n);
        return (n <= 4'd1) ? LAST_SONG : n - 4'd1;
    endfunction

    state_e     state_q;
    logic [3:0] num_q;
    logic [3:0] sel_song_q;
    logic       sel_valid_q;

    logic up_lvl, up_rise;
    logic dn_lvl, dn_rise;
    logic sel_lvl, sel_rise;
    logic rep_up, rep_dn;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
        .clk(clk), .rst_n(rst_n), .btn_i(btn_up), .level_o(up_lvl), .rise_o(up_rise)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
        .clk(clk), .rst_n(rst_n), .btn_i(btn_down), .level_o(dn_lvl), .rise_o(dn_rise)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_sel (
        .clk(clk), .rst_n(rst_n), .btn_i(btn_sel), .level_o(sel_lvl), .rise_o(sel_rise)
    );

`ifdef SONG_SELECTOR_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES) + 1;
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

    logic [RW-1:0] rep_cnt_q;
    logic          hold_one;
    logic          rep_fire;
    logic          lvl_unused;

    // Only a single held direction repeats; holding both cancels out like simultaneous presses.
    assign hold_one   = up_lvl ^ dn_lvl;
    assign rep_fire   = (state_q == BROWSE) && hold_one && (rep_cnt_q == REP_LAST);
    assign rep_up     = rep_fire && up_lvl;
    assign rep_dn     = rep_fire && dn_lvl;
    assign lvl_unused = sel_lvl;

    always_ff @(posedge clk) begin
        if (!rst_n || state_q != BROWSE || !hold_one || rep_cnt_q == REP_LAST) begin
            rep_cnt_q <= '0;
        end else begin
            rep_cnt_q <= rep_cnt_q + 1'b1;
        end
    end
`else
    logic lvl_unused;
    assign rep_up     = 1'b0;
    assign rep_dn     = 1'b0;
    assign lvl_unused = up_lvl ^ dn_lvl ^ sel_lvl;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            num_q       <= 4'd1;
            sel_song_q  <= 4'd0;
            sel_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mode == MODE_BROWSE) begin
                        state_q <= BROWSE;
                    end
                end
                BROWSE: begin
                    // Select wins over a same-cycle step, and that step is discarded.
                    if (mode != MODE_BROWSE) begin
                        state_q <= IDLE;
                    end else if (sel_rise) begin
                        sel_song_q  <= num_q;
                        sel_valid_q <= 1'b1;
                        state_q     <= REQ;
                    end else if (up_rise && !dn_rise) begin
                        num_q <= num_inc(num_q);
                    end else if (dn_rise && !up_rise) begin
                        num_q <= num_dec(num_q);
                    end else if (!up_rise && !dn_rise && rep_up) begin
                        num_q <= num_inc(num_q);
                    end else if (!up_rise && !dn_rise && rep_dn) begin
                        num_q <= num_dec(num_q);
                    end
                end
                REQ: begin
                    if (sel_ready) begin
                        sel_valid_q <= 1'b0;
                        state_q     <= (mode == MODE_BROWSE) ? BROWSE : IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    sel_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign num       = num_q;
    assign sel_valid = sel_valid_q;
    assign sel_song  = sel_song_q;

endmodule

// File: tb/tb_song_selector.sv
// Directed self-checking bench for song_selector (DEBOUNCE_CYCLES=4, NUM_SONGS=3, REPEAT_CYCLES=8).
module tb_song_selector;

    logic       clk;
    logic       rst_n;
    logic       btn_up;
    logic       btn_down;
    logic       btn_sel;
    logic [2:0] mode;
    logic [3:0] num;
    logic       sel_valid;
    logic [3:0] sel_song;
    logic       sel_ready;

    int n_tests;
    int n_fail;

    song_selector #(
        .DEBOUNCE_CYCLES(4),
        .NUM_SONGS(3),
        .REPEAT_CYCLES(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .btn_up(btn_up),
        .btn_down(btn_down),
        .btn_sel(btn_sel),
        .mode(mode),
        .num(num),
        .sel_valid(sel_valid),
        .sel_song(sel_song),
        .sel_ready(sel_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hold the chosen raw buttons for 'hold' cycles, release, then let the debouncers settle.
    task automatic press(input logic u, input logic d, input logic s, input int hold);
        btn_up   = u;
        btn_down = d;
        btn_sel  = s;
        repeat (hold) @(negedge clk);
        btn_up   = 1'b0;
        btn_down = 1'b0;
        btn_sel  = 1'b0;
        repeat (14) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (num !== 4'd1) begin n_fail++; $display("FAIL reset_num got=%0d exp=1", num); end
        n_tests++;
        if (sel_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", sel_valid); end
        n_tests++;
        if (sel_song !== 4'd0) begin n_fail++; $display("FAIL reset_song got=%0d exp=0", sel_song); end
        rst_n = 1'b1;
        mode  = 3'd1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_press();
        press(1'b1, 1'b0, 1'b0, 6);
        n_tests++;
        if (num !== 4'd2) begin n_fail++; $display("FAIL single_up got=%0d exp=2", num); end
        repeat (10) @(negedge clk);
        n_tests++;
        if (num !== 4'd2) begin n_fail++; $display("FAIL single_up_once got=%0d exp=2", num); end
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 10; i++) begin
            btn_up = ((i / 2) % 2 == 0);
            @(negedge clk);
        end
        n_tests++;
        if (num !== 4'd2) begin n_fail++; $display("FAIL bounce_early got=%0d exp=2", num); end
        press(1'b1, 1'b0, 1'b0, 4);
        n_tests++;
        if (num !== 4'd3) begin n_fail++; $display("FAIL bounce_one_step got=%0d exp=3", num); end
    endtask

    task automatic test_wrap();
        press(1'b1, 1'b0, 1'b0, 6);
        n_tests++;
        if (num !== 4'd1) begin n_fail++; $display("FAIL wrap_up got=%0d exp=1", num); end
        press(1'b0, 1'b1, 1'b0, 6);
        n_tests++;
        if (num !== 4'd3) begin n_fail++; $display("FAIL wrap_down got=%0d exp=3", num); end
        press(1'b0, 1'b1, 1'b0, 6);
        n_tests++;
        if (num !== 4'd2) begin n_fail++; $display("FAIL down_step got=%0d exp=2", num); end
    endtask

    task automatic test_handshake();
        sel_ready = 1'b0;
        press(1'b0, 1'b0, 1'b1, 6);
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (sel_valid !== 1'b1 || sel_song !== 4'd2) begin
                n_fail++;
                $display("FAIL req_hold cyc=%0d valid=%b song=%0d exp valid=1 song=2", i, sel_valid, sel_song);
            end
            @(negedge clk);
        end
        press(1'b1, 1'b0, 1'b0, 6);
        n_tests++;
        if (num !== 4'd2 || sel_song !== 4'd2 || sel_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL req_ignore num=%0d song=%0d valid=%b exp num=2 song=2 valid=1", num, sel_song, sel_valid);
        end
        sel_ready = 1'b1;
        @(negedge clk);
        sel_ready = 1'b0;
        n_tests++;
        if (sel_valid !== 1'b0) begin n_fail++; $display("FAIL handshake_done got=%b exp=0", sel_valid); end
        press(1'b1, 1'b0, 1'b0, 6);
        n_tests++;
        if (num !== 4'd3) begin n_fail++; $display("FAIL back_in_browse got=%0d exp=3", num); end
        press(1'b0, 1'b1, 1'b0, 6);
    endtask

    task automatic test_simultaneous();
        press(1'b1, 1'b1, 1'b0, 6);
        n_tests++;
        if (num !== 4'd2) begin n_fail++; $display("FAIL up_down_same got=%0d exp=2", num); end
    endtask

    task automatic test_mode_exit();
        mode = 3'd0;
        repeat (2) @(negedge clk);
        press(1'b1, 1'b0, 1'b0, 6);
        n_tests++;
        if (num !== 4'd2) begin n_fail++; $display("FAIL idle_ignore_up got=%0d exp=2", num); end
        press(1'b0, 1'b0, 1'b1, 6);
        n_tests++;
        if (sel_valid !== 1'b0) begin n_fail++; $display("FAIL idle_ignore_sel got=%b exp=0", sel_valid); end
        mode = 3'd1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_autorepeat();
        int changes;
        int exp_changes;
        logic [3:0] prev;
`ifdef SONG_SELECTOR_AUTOREPEAT_EN
        exp_changes = 4;
`else
        exp_changes = 1;
`endif
        changes = 0;
        prev    = num;
        btn_up  = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (i == 27) btn_up = 1'b0;
            if (num !== prev) changes++;
            prev = num;
        end
        n_tests++;
        if (changes !== exp_changes) begin
            n_fail++;
            $display("FAIL autorepeat_steps got=%0d exp=%0d", changes, exp_changes);
        end
    endtask

    task automatic test_reset_mid_handshake();
        logic [3:0] cur;
        cur = num;
        sel_ready = 1'b0;
        press(1'b0, 1'b0, 1'b1, 6);
        n_tests++;
        if (sel_valid !== 1'b1 || sel_song !== cur) begin
            n_fail++;
            $display("FAIL pre_reset_req valid=%b song=%0d exp valid=1 song=%0d", sel_valid, sel_song, cur);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_tests++;
        if (sel_valid !== 1'b0 || sel_song !== 4'd0 || num !== 4'd1) begin
            n_fail++;
            $display("FAIL reset_mid_req valid=%b song=%0d num=%0d exp 0/0/1", sel_valid, sel_song, num);
        end
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        btn_up    = 1'b0;
        btn_down  = 1'b0;
        btn_sel   = 1'b0;
        mode      = 3'd0;
        sel_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_press();
        test_bounce();
        test_wrap();
        test_handshake();
        test_simultaneous();
        test_mode_exit();
        test_autorepeat();
        test_reset_mid_handshake();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
